// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: stream bundle between the multiplier side, the
// accumulator and the consumer of finished sums.
//
// Signals:
//   in_valid  / in_ready / p       : product stream into the accumulator
//   out_valid / out_ready / acc_out: finished-sum stream out of it
//
// Handshake rule (both streams): a transfer happens on a rising clock edge
// where valid and ready are both high. A source keeps valid and its data
// stable until that transfer. in_ready never depends on in_valid.
//
// Modports:
//   master : the environment (drives products and out_ready)
//   slave  : the accumulator (drives in_ready and the result stream)
interface mac_accumulator_if #(
    parameter int ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       p;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;

    modport master (
        output in_valid,
        output p,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc_out
    );

    modport slave (
        input  in_valid,
        input  p,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc_out
    );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums LEN consecutive 8-bit unsigned products into an
// ACC_W-bit dot product and offers the finished sum on a valid/ready port.
// The result is held under backpressure and overflow is reported as a sticky
// flag.
//
// Parameters:
//   LEN   : products per result, 1..255
//   ACC_W : accumulator / result width, >= 8
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   ena       : global enable; low freezes every register and drops in_ready
//   clear     : synchronous flush back to IDLE (only acts while ena is high)
//   bus       : mac_accumulator_if.slave (product in, result out)
//   count     : products accepted into the current sum
//   overflow  : the current or held sum went past 2^ACC_W - 1
//   state_dbg : FSM state, IDLE=0, ACCUM=1, HOLD=2
//
// Build option:
//   MAC_ACCUMULATOR_SATURATE_EN : when defined, an overflowing add clamps the
//   accumulator at 2^ACC_W - 1; otherwise the sum wraps modulo 2^ACC_W.
module mac_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    mac_accumulator_if.slave bus,
    output logic [7:0]       count,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PAD = ACC_W + 1 - 8;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] sum_next;
    logic             in_ready;
    logic             accept;
    logic             last_accept;

    // A new sum always starts from zero, whatever acc_q happens to hold.
    assign acc_base = (state_q == ACCUM) ? acc_q : '0;
    assign sum_ext  = {1'b0, acc_base} + {{PAD{1'b0}}, bus.p};
    assign carry    = sum_ext[ACC_W];

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    // Once clamped, every later add carries again, so the value stays pinned.
    assign sum_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign sum_next = sum_ext[ACC_W-1:0];
`endif

    assign in_ready    = ena && (state_q != HOLD) && !clear;
    assign accept      = bus.in_valid && in_ready;
    assign last_accept = (count_q == 8'(LEN - 1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (ena) begin
            if (clear) begin
                state_d     = IDLE;
                acc_d       = '0;
                acc_out_d   = '0;
                count_d     = '0;
                ovf_d       = 1'b0;
                out_valid_d = 1'b0;
            end else begin
                case (state_q)
                    IDLE, ACCUM: begin
                        if (accept) begin
                            acc_d   = sum_next;
                            count_d = count_q + 8'd1;
                            // ovf_q is zero in IDLE, so this also starts fresh.
                            ovf_d   = ovf_q | carry;
                            if (last_accept) begin
                                acc_out_d   = sum_next;
                                out_valid_d = 1'b1;
                                state_d     = HOLD;
                            end else begin
                                state_d = ACCUM;
                            end
                        end
                    end
                    HOLD: begin
                        // acc_out keeps the delivered value until the next result.
                        if (out_valid_q && bus.out_ready) begin
                            out_valid_d = 1'b0;
                            acc_d       = '0;
                            count_d     = '0;
                            ovf_d       = 1'b0;
                            state_d     = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            acc_out_q   <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: three accumulators driven by the same stimulus.
//   dut 0 : LEN=4, ACC_W=12 (main configuration)
//   dut 1 : LEN=4, ACC_W=9  (overflows on large products)
//   dut 2 : LEN=1, ACC_W=12 (one product per result)
// Each dut is tracked by a transaction-level model: the true sum as an
// integer, a product count, whether a result is waiting, and the delivered
// result value. Results of dut 0 also go through an expected queue that is
// checked when the consumer takes them.
module tb_mac_accumulator;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic       drv_ena;
    logic       drv_clear;
    logic       drv_valid;
    logic [7:0] drv_p;
    logic       drv_ordy;

    mac_accumulator_if #(.ACC_W(12)) if0 ();
    mac_accumulator_if #(.ACC_W(9))  if1 ();
    mac_accumulator_if #(.ACC_W(12)) if2 ();

    assign if0.in_valid  = drv_valid;
    assign if0.p         = drv_p;
    assign if0.out_ready = drv_ordy;
    assign if1.in_valid  = drv_valid;
    assign if1.p         = drv_p;
    assign if1.out_ready = drv_ordy;
    assign if2.in_valid  = drv_valid;
    assign if2.p         = drv_p;
    assign if2.out_ready = drv_ordy;

    logic [7:0] cnt0, cnt1, cnt2;
    logic       ovf0, ovf1, ovf2;
    logic [1:0] dbg0, dbg1, dbg2;

    mac_accumulator #(.LEN(4), .ACC_W(12)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(drv_ena), .clear(drv_clear),
        .bus(if0), .count(cnt0), .overflow(ovf0), .state_dbg(dbg0)
    );
    mac_accumulator #(.LEN(4), .ACC_W(9)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(drv_ena), .clear(drv_clear),
        .bus(if1), .count(cnt1), .overflow(ovf1), .state_dbg(dbg1)
    );
    mac_accumulator #(.LEN(1), .ACC_W(12)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(drv_ena), .clear(drv_clear),
        .bus(if2), .count(cnt2), .overflow(ovf2), .state_dbg(dbg2)
    );

    // Observed outputs gathered into arrays so checks can loop over duts.
    logic        obs_rdy[3];
    logic        obs_ov[3];
    logic [11:0] obs_acc[3];
    logic [7:0]  obs_cnt[3];
    logic        obs_ovf[3];
    logic [1:0]  obs_dbg[3];

    assign obs_rdy[0] = if0.in_ready;
    assign obs_rdy[1] = if1.in_ready;
    assign obs_rdy[2] = if2.in_ready;
    assign obs_ov[0]  = if0.out_valid;
    assign obs_ov[1]  = if1.out_valid;
    assign obs_ov[2]  = if2.out_valid;
    assign obs_acc[0] = if0.acc_out;
    assign obs_acc[1] = {3'b000, if1.acc_out};
    assign obs_acc[2] = if2.acc_out;
    assign obs_cnt[0] = cnt0;
    assign obs_cnt[1] = cnt1;
    assign obs_cnt[2] = cnt2;
    assign obs_ovf[0] = ovf0;
    assign obs_ovf[1] = ovf1;
    assign obs_ovf[2] = ovf2;
    assign obs_dbg[0] = dbg0;
    assign obs_dbg[1] = dbg1;
    assign obs_dbg[2] = dbg2;

    // ---------------- reference model ----------------
    localparam int LENS[3] = '{4, 4, 1};
    localparam int ACCW[3] = '{12, 9, 12};

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    localparam int OVF_SUM = 511;
`else
    localparam int OVF_SUM = 388;
`endif

    int m_sum[3];   // true (unbounded) sum of the current or held result
    int m_n[3];     // products accepted into it
    bit m_hold[3];  // a finished result is waiting for the consumer
    int m_out[3];   // value on acc_out

    logic [11:0] exp_q[$];  // finished results of dut 0, oldest first

    // Values captured just before the clock edge of the last drive_cycle.
    logic        pre_rdy[3];
    bit          exp_rdy[3];
    logic        pre_ov0;
    logic [11:0] pre_acc0;

    int n_checks;
    int n_fail;

    function automatic int max_of(int k);
        return (1 << ACCW[k]) - 1;
    endfunction

    function automatic int fold(int k, int s);
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        return (s > max_of(k)) ? max_of(k) : s;
`else
        return s % (max_of(k) + 1);
`endif
    endfunction

    function automatic bit exp_ovf(int k);
        return m_sum[k] > max_of(k);
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin
            m_sum[k]  = 0;
            m_n[k]    = 0;
            m_hold[k] = 1'b0;
            m_out[k]  = 0;
        end
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: applies inputs, samples the ready outputs,
    // clocks once, advances the model and returns at the next falling edge.
    task automatic drive_cycle(input bit e, input bit c, input bit v,
                               input int pv, input bit r);
        drv_ena   = e;
        drv_clear = c;
        drv_valid = v;
        drv_p     = 8'(pv);
        drv_ordy  = r;
        #1;
        for (int k = 0; k < 3; k++) begin
            pre_rdy[k] = obs_rdy[k];
            exp_rdy[k] = e && !m_hold[k] && !c;
        end
        pre_ov0  = obs_ov[0];
        pre_acc0 = obs_acc[0];
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (e) begin
                if (c) begin
                    m_sum[k]  = 0;
                    m_n[k]    = 0;
                    m_hold[k] = 1'b0;
                    m_out[k]  = 0;
                    if (k == 0) exp_q.delete();
                end else if (m_hold[k]) begin
                    if (r) begin
                        m_hold[k] = 1'b0;
                        m_sum[k]  = 0;
                        m_n[k]    = 0;
                    end
                end else if (v) begin
                    m_sum[k] += (pv & 255);
                    m_n[k]   += 1;
                    if (m_n[k] == LENS[k]) begin
                        m_hold[k] = 1'b1;
                        m_out[k]  = fold(k, m_sum[k]);
                        if (k == 0) exp_q.push_back(12'(m_out[k]));
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drv_ena = 1'b0; drv_clear = 1'b0; drv_valid = 1'b0;
        drv_p = 8'd0; drv_ordy = 1'b0;
        reset_model();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks += 5;
            if (obs_ov[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid dut%0d: got %0d want 0", k, obs_ov[k]); end
            if (obs_acc[k] !== 12'd0) begin n_fail++; $display("FAIL reset_acc_out dut%0d: got %0d want 0", k, obs_acc[k]); end
            if (obs_cnt[k] !== 8'd0) begin n_fail++; $display("FAIL reset_count dut%0d: got %0d want 0", k, obs_cnt[k]); end
            if (obs_ovf[k] !== 1'b0) begin n_fail++; $display("FAIL reset_overflow dut%0d: got %0d want 0", k, obs_ovf[k]); end
            if (obs_dbg[k] !== 2'd0) begin n_fail++; $display("FAIL reset_state dut%0d: got %0d want 0", k, obs_dbg[k]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_sum();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 0, 1, 225, 0);
            n_checks += 2;
            if (pre_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready beat%0d: got %0d want 1", i, pre_rdy[0]); end
            if (obs_ov[0] !== (i == 3)) begin n_fail++; $display("FAIL basic_out_valid beat%0d: got %0d want %0d", i, obs_ov[0], (i == 3)); end
        end
        n_checks += 8;
        if (obs_acc[0] !== 12'd900) begin n_fail++; $display("FAIL basic_acc_out: got %0d want 900", obs_acc[0]); end
        if (obs_cnt[0] !== 8'd4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", obs_cnt[0]); end
        if (obs_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %0d want 0", obs_ovf[0]); end
        if (obs_acc[1] !== 12'(OVF_SUM)) begin n_fail++; $display("FAIL ovf_acc_out: got %0d want %0d", obs_acc[1], OVF_SUM); end
        if (obs_ovf[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0d want 1", obs_ovf[1]); end
        if (obs_ov[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_out_valid: got %0d want 1", obs_ov[1]); end
        if (obs_acc[2] !== 12'd225) begin n_fail++; $display("FAIL len1_acc_out: got %0d want 225", obs_acc[2]); end
        if (obs_ov[2] !== 1'b1) begin n_fail++; $display("FAIL len1_out_valid: got %0d want 1", obs_ov[2]); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, 0, 1, 33, 0);
            n_checks += 3;
            if (pre_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d: got %0d want 0", i, pre_rdy[0]); end
            if (obs_ov[0] !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc%0d: got %0d want 1", i, obs_ov[0]); end
            if (obs_acc[0] !== 12'd900) begin n_fail++; $display("FAIL bp_acc_out cyc%0d: got %0d want 900", i, obs_acc[0]); end
        end
        drive_cycle(1, 0, 1, 33, 1);
        n_checks += 5;
        if (pre_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL hs_in_ready: got %0d want 0", pre_rdy[0]); end
        if (obs_ov[0] !== 1'b0) begin n_fail++; $display("FAIL hs_out_valid: got %0d want 0", obs_ov[0]); end
        if (obs_cnt[0] !== 8'd0) begin n_fail++; $display("FAIL hs_count: got %0d want 0", obs_cnt[0]); end
        if (obs_ovf[1] !== 1'b0) begin n_fail++; $display("FAIL hs_overflow_cleared: got %0d want 0", obs_ovf[1]); end
        if (obs_ov[1] !== 1'b0) begin n_fail++; $display("FAIL hs_out_valid dut1: got %0d want 0", obs_ov[1]); end
        drive_cycle(1, 0, 1, 33, 0);
        n_checks += 2;
        if (pre_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL post_hs_in_ready: got %0d want 1", pre_rdy[0]); end
        if (obs_cnt[0] !== 8'd1) begin n_fail++; $display("FAIL post_hs_count: got %0d want 1", obs_cnt[0]); end
    endtask

    task automatic test_clear();
        drive_cycle(1, 1, 0, 0, 0);
        n_checks += 1;
        if (obs_cnt[0] !== 8'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", obs_cnt[0]); end
        drive_cycle(1, 0, 1, 10, 1);
        drive_cycle(1, 0, 1, 20, 1);
        n_checks += 1;
        if (obs_cnt[0] !== 8'd2) begin n_fail++; $display("FAIL pre_clear_count: got %0d want 2", obs_cnt[0]); end
        drive_cycle(1, 1, 1, 30, 1);
        n_checks += 5;
        if (pre_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %0d want 0", pre_rdy[0]); end
        if (obs_cnt[0] !== 8'd0) begin n_fail++; $display("FAIL clear_count: got %0d want 0", obs_cnt[0]); end
        if (obs_ov[0] !== 1'b0) begin n_fail++; $display("FAIL clear_out_valid: got %0d want 0", obs_ov[0]); end
        if (obs_acc[0] !== 12'd0) begin n_fail++; $display("FAIL clear_acc_out: got %0d want 0", obs_acc[0]); end
        if (obs_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL clear_overflow: got %0d want 0", obs_ovf[0]); end
        for (int i = 1; i <= 4; i++) drive_cycle(1, 0, 1, i, 0);
        n_checks += 2;
        if (obs_ov[0] !== 1'b1) begin n_fail++; $display("FAIL after_clear_out_valid: got %0d want 1", obs_ov[0]); end
        if (obs_acc[0] !== 12'd10) begin n_fail++; $display("FAIL after_clear_acc_out: got %0d want 10", obs_acc[0]); end
        drive_cycle(1, 0, 0, 0, 1);
    endtask

    task automatic test_enable_freeze();
        int a;
        int b;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        drive_cycle(1, 0, 1, a, 0);
        drive_cycle(1, 0, 1, b, 0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, i[0], !i[0], $urandom_range(0, 255), 1);
            n_checks += 3;
            if (pre_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL freeze_in_ready cyc%0d: got %0d want 0", i, pre_rdy[0]); end
            if (obs_cnt[0] !== 8'd2) begin n_fail++; $display("FAIL freeze_count cyc%0d: got %0d want 2", i, obs_cnt[0]); end
            if (obs_ov[0] !== 1'b0) begin n_fail++; $display("FAIL freeze_out_valid cyc%0d: got %0d want 0", i, obs_ov[0]); end
        end
        drive_cycle(1, 0, 1, 5, 0);
        drive_cycle(1, 0, 1, 5, 0);
        n_checks += 3;
        if (obs_ov[0] !== 1'b1) begin n_fail++; $display("FAIL resume_out_valid: got %0d want 1", obs_ov[0]); end
        if (obs_acc[0] !== 12'(a + b + 10)) begin n_fail++; $display("FAIL resume_acc_out: got %0d want %0d", obs_acc[0], a + b + 10); end
        if (obs_cnt[0] !== 8'd4) begin n_fail++; $display("FAIL resume_count: got %0d want 4", obs_cnt[0]); end
        drive_cycle(1, 0, 0, 0, 1);
    endtask

    task automatic test_async_reset_hold();
        int x;
        int y;
        for (int i = 0; i < 4; i++) drive_cycle(1, 0, 1, $urandom_range(100, 255), 0);
        n_checks += 1;
        if (obs_ov[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_hold: got %0d want 1", obs_ov[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks += 4;
            if (obs_ov[k] !== 1'b0) begin n_fail++; $display("FAIL async_out_valid dut%0d: got %0d want 0", k, obs_ov[k]); end
            if (obs_acc[k] !== 12'd0) begin n_fail++; $display("FAIL async_acc_out dut%0d: got %0d want 0", k, obs_acc[k]); end
            if (obs_cnt[k] !== 8'd0) begin n_fail++; $display("FAIL async_count dut%0d: got %0d want 0", k, obs_cnt[k]); end
            if (obs_ovf[k] !== 1'b0) begin n_fail++; $display("FAIL async_overflow dut%0d: got %0d want 0", k, obs_ovf[k]); end
        end
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        x = $urandom_range(1, 255);
        y = $urandom_range(1, 255);
        drive_cycle(1, 0, 1, x, 0);
        n_checks += 3;
        if (obs_ov[2] !== 1'b1) begin n_fail++; $display("FAIL len1_first_out_valid: got %0d want 1", obs_ov[2]); end
        if (obs_acc[2] !== 12'(x)) begin n_fail++; $display("FAIL len1_first_acc_out: got %0d want %0d", obs_acc[2], x); end
        if (obs_cnt[2] !== 8'd1) begin n_fail++; $display("FAIL len1_count: got %0d want 1", obs_cnt[2]); end
        drive_cycle(1, 0, 1, y, 1);
        n_checks += 2;
        if (pre_rdy[2] !== 1'b0) begin n_fail++; $display("FAIL len1_hs_in_ready: got %0d want 0", pre_rdy[2]); end
        if (obs_ov[2] !== 1'b0) begin n_fail++; $display("FAIL len1_hs_out_valid: got %0d want 0", obs_ov[2]); end
        drive_cycle(1, 0, 1, y, 0);
        n_checks += 3;
        if (pre_rdy[2] !== 1'b1) begin n_fail++; $display("FAIL len1_second_in_ready: got %0d want 1", pre_rdy[2]); end
        if (obs_ov[2] !== 1'b1) begin n_fail++; $display("FAIL len1_second_out_valid: got %0d want 1", obs_ov[2]); end
        if (obs_acc[2] !== 12'(y)) begin n_fail++; $display("FAIL len1_second_acc_out: got %0d want %0d", obs_acc[2], y); end
    endtask

    task automatic test_random();
        bit e, c, v, r;
        int pv;
        logic [11:0] want;
        rst_n = 1'b0;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            e  = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 24) == 0);
            v  = ($urandom_range(0, 3) != 0);
            pv = $urandom_range(0, 255);
            r  = ($urandom_range(0, 2) != 0);
            drive_cycle(e, c, v, pv, r);
            // Scoreboard: a result taken by the consumer must be the oldest expected.
            if (e && !c && pre_ov0 && r) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL sb_unexpected_result cyc%0d: got %0d want none", n, pre_acc0);
                end else begin
                    want = exp_q.pop_front();
                    if (pre_acc0 !== want) begin n_fail++; $display("FAIL sb_result cyc%0d: got %0d want %0d", n, pre_acc0, want); end
                end
            end
            for (int k = 0; k < 3; k++) begin
                n_checks += 5;
                if (pre_rdy[k] !== exp_rdy[k]) begin n_fail++; $display("FAIL rnd_in_ready dut%0d cyc%0d: got %0d want %0d", k, n, pre_rdy[k], exp_rdy[k]); end
                if (obs_ov[k] !== m_hold[k]) begin n_fail++; $display("FAIL rnd_out_valid dut%0d cyc%0d: got %0d want %0d", k, n, obs_ov[k], m_hold[k]); end
                if (obs_acc[k] !== 12'(m_out[k])) begin n_fail++; $display("FAIL rnd_acc_out dut%0d cyc%0d: got %0d want %0d", k, n, obs_acc[k], m_out[k]); end
                if (obs_cnt[k] !== 8'(m_n[k])) begin n_fail++; $display("FAIL rnd_count dut%0d cyc%0d: got %0d want %0d", k, n, obs_cnt[k], m_n[k]); end
                if (obs_ovf[k] !== exp_ovf(k)) begin n_fail++; $display("FAIL rnd_overflow dut%0d cyc%0d: got %0d want %0d", k, n, obs_ovf[k], exp_ovf(k)); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_sum();
        test_backpressure();
        test_clear();
        test_enable_freeze();
        test_async_reset_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
